// File: rtl/lifo_fifo_buf_pkg.sv
// Purpose : shared types and helpers for the run-time selectable LIFO/FIFO buffer.
// Latency : n/a (types and functions only).
// Backpressure: n/a.
package lifo_pkg;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_LIFO = 1'b1
  } mode_t;

  // Mode-load FSM: a new mode may only be taken while the buffer is empty.
  typedef enum logic {
    ST_IDLE_EMPTY = 1'b0,
    ST_ACTIVE     = 1'b1
  } state_t;

  function automatic int unsigned depth(input int unsigned awidth_exp);
    return 32'd1 << awidth_exp;
  endfunction

endpackage

// File: rtl/lifo_fifo_buf_if.sv
// Purpose : producer/consumer bundle for lifo_fifo_buf (write side, read side, status).
// Latency : n/a (wiring only).
// Backpressure: n/a; full_o/empty_o and the sticky error flags report dropped requests.
// Ports   : data_i/wrreq_i/rdreq_i/mode_i/clr_err_i driven by master; q_o and status by slave.
interface lifo_fifo_buf_if #(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH_EXP = 3
);
  logic [DWIDTH-1:0]   data_i;
  logic                wrreq_i;
  logic                rdreq_i;
  logic                mode_i;
  logic                clr_err_i;
  logic [DWIDTH-1:0]   q_o;
  logic                empty_o;
  logic                full_o;
  logic                almost_full_o;
  logic                almost_empty_o;
  logic [AWIDTH_EXP:0] usedw_o;
  logic                mode_o;
  logic                ovf_o;
  logic                udf_o;

  modport master (
    output data_i, wrreq_i, rdreq_i, mode_i, clr_err_i,
    input  q_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o, mode_o, ovf_o, udf_o
  );

  modport slave (
    input  data_i, wrreq_i, rdreq_i, mode_i, clr_err_i,
    output q_o, empty_o, full_o, almost_full_o, almost_empty_o, usedw_o, mode_o, ovf_o, udf_o
  );
endinterface

// File: rtl/lifo_fifo_buf_mem.sv
// Purpose : DEPTH x DWIDTH storage array, synchronous write, asynchronous read.
// Latency : write lands on the clock edge; read data follows raddr_i combinationally.
// Backpressure: none; the caller decides which writes are accepted.
// Ports   : clk_i, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port.
module lifo_mem
  import lifo_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int AWIDTH_EXP = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AWIDTH_EXP-1:0] waddr_i,
  input  logic [DWIDTH-1:0]     wdata_i,
  input  logic [AWIDTH_EXP-1:0] raddr_i,
  output logic [DWIDTH-1:0]     rdata_o
);
  localparam int unsigned DEPTH = depth(AWIDTH_EXP);

  // Contents are deliberately not reset.
  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_fifo_buf.sv
// Purpose : single-clock elastic buffer, stack or queue selected at run time, sticky ovf/udf.
// Latency : q_o valid the cycle after an accepted read; all status registered, no input->output path.
// Backpressure: writes when full (without a read) and reads when empty are dropped and flagged.
// Ports   : clk_i, arst_n_i (async active-low), bus (lifo_fifo_buf_if.slave).
module lifo_fifo_buf
  import lifo_pkg::*;
#(
  parameter int    DWIDTH       = 8,
  parameter int    AWIDTH_EXP   = 3,
  parameter int    AF_THR       = 2**AWIDTH_EXP - 2,
  parameter int    AE_THR       = 1,
  parameter mode_t MODE_DEFAULT = MODE_LIFO
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  lifo_fifo_buf_if.slave  bus
);
  localparam int unsigned         DEPTH   = depth(AWIDTH_EXP);
  localparam logic [AWIDTH_EXP:0] DEPTH_W = (AWIDTH_EXP+1)'(DEPTH);

  logic [AWIDTH_EXP:0]   usedw_q, usedw_d;
  logic [AWIDTH_EXP-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DWIDTH-1:0]     q_q, q_d;
  mode_t                 mode_q, mode_d;
  state_t                state_q, state_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  af_q, af_d, ae_q, ae_d;

  logic                  rd_acc, wr_acc, mode_ld;
  logic [AWIDTH_EXP-1:0] top_addr, waddr, raddr;
  logic [DWIDTH-1:0]     rdata;

  always_comb begin
    // A read frees a slot, so rd+wr is accepted even when full; on empty the read drops.
    rd_acc   = bus.rdreq_i & ~empty_q;
    wr_acc   = bus.wrreq_i & (~full_q | rd_acc);
    // Wraps to DEPTH-1 when usedw == DEPTH, which is exactly the top of a full stack.
    top_addr = usedw_q[AWIDTH_EXP-1:0] - AWIDTH_EXP'(1);

    if (mode_q == MODE_LIFO) begin
      raddr = top_addr;
      // rd+wr on a stack overwrites the popped top rather than pushing above it.
      waddr = rd_acc ? top_addr : usedw_q[AWIDTH_EXP-1:0];
    end else begin
      raddr = rd_ptr_q;
      waddr = wr_ptr_q;
    end

    usedw_d = usedw_q;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + (AWIDTH_EXP+1)'(1);
      2'b01:   usedw_d = usedw_q - (AWIDTH_EXP+1)'(1);
      default: usedw_d = usedw_q;
    endcase

    q_d = rd_acc ? rdata : q_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (mode_q == MODE_FIFO) begin
      wr_ptr_d = wr_ptr_q + AWIDTH_EXP'(wr_acc);
      rd_ptr_d = rd_ptr_q + AWIDTH_EXP'(rd_acc);
    end

    // Mode may only change while empty and with no write landing on this edge.
    mode_ld = (state_q == ST_IDLE_EMPTY) && !bus.wrreq_i;
    mode_d  = mode_ld ? mode_t'(bus.mode_i) : mode_q;
    if (mode_d != mode_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    state_d = (usedw_d == '0) ? ST_IDLE_EMPTY : ST_ACTIVE;

    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d = (ovf_q & ~bus.clr_err_i) | (bus.wrreq_i & ~wr_acc);
    udf_d = (udf_q & ~bus.clr_err_i) | (bus.rdreq_i & ~rd_acc);

    empty_d = (usedw_d == '0);
    full_d  = (usedw_d == DEPTH_W);
    af_d    = int'(usedw_d) >= AF_THR;
    ae_d    = int'(usedw_d) <= AE_THR;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      usedw_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_q     <= '0;
      mode_q  <= MODE_DEFAULT;
      state_q <= ST_IDLE_EMPTY;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= (AF_THR == 0);
      ae_q    <= 1'b1;
    end else begin
      usedw_q <= usedw_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  end

  lifo_mem #(
    .DWIDTH     (DWIDTH),
    .AWIDTH_EXP (AWIDTH_EXP)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (waddr),
    .wdata_i (bus.data_i),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign bus.q_o            = q_q;
  assign bus.usedw_o        = usedw_q;
  assign bus.empty_o        = empty_q;
  assign bus.full_o         = full_q;
  assign bus.almost_full_o  = af_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.mode_o         = mode_q;
  assign bus.ovf_o          = ovf_q;
  assign bus.udf_o          = udf_q;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Purpose : directed, table-driven check of lifo_fifo_buf in both modes, DEPTH=8.
// Latency : each vector is applied for one edge and outputs compared 1 time unit later.
// Backpressure: overflow/underflow cases are part of the vector table.
module tb_lifo_fifo_buf;
  import lifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  lifo_fifo_buf_if #(.DWIDTH(DW), .AWIDTH_EXP(AW)) bus ();

  lifo_fifo_buf #(
    .DWIDTH       (DW),
    .AWIDTH_EXP   (AW),
    .AF_THR       (AF),
    .AE_THR       (AE),
    .MODE_DEFAULT (MODE_LIFO)
  ) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic       md;
    logic       clr;
    logic [7:0] d;
    int         e_used;
    logic [7:0] e_q;
    logic       e_mode;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic wr, rd, md, clr, input logic [7:0] d,
                              input int used, input logic [7:0] q,
                              input logic m, ov, ud);
    vec_t v;
    v.wr = wr; v.rd = rd; v.md = md; v.clr = clr; v.d = d;
    v.e_used = used; v.e_q = q; v.e_mode = m; v.e_ovf = ov; v.e_udf = ud;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Status flags are derived from the expected fill level using the thresholds above.
  task automatic chk_state(input string tag, input int u, input logic [7:0] q,
                           input logic m, input logic ov, input logic ud);
    chk({tag, ".usedw"}, 32'(bus.usedw_o), u);
    chk({tag, ".q"},     32'(bus.q_o), 32'(q));
    chk({tag, ".mode"},  32'(bus.mode_o), 32'(m));
    chk({tag, ".ovf"},   32'(bus.ovf_o), 32'(ov));
    chk({tag, ".udf"},   32'(bus.udf_o), 32'(ud));
    chk({tag, ".empty"}, 32'(bus.empty_o), 32'(u == 0));
    chk({tag, ".full"},  32'(bus.full_o), 32'(u == DEPTH));
    chk({tag, ".af"},    32'(bus.almost_full_o), 32'(u >= AF));
    chk({tag, ".ae"},    32'(bus.almost_empty_o), 32'(u <= AE));
  endtask

  task automatic drive(input logic wr, rd, md, clr, input logic [7:0] d);
    bus.wrreq_i   = wr;
    bus.rdreq_i   = rd;
    bus.mode_i    = md;
    bus.clr_err_i = clr;
    bus.data_i    = d;
  endtask

  task automatic cyc(input logic wr, rd, md, clr, input logic [7:0] d);
    drive(wr, rd, md, clr, d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 8'd0, 1'b1, 1'b0, 1'b0);
    #2 arst_n = 1'b1;

    // LIFO fill, overflow, drain in reverse order, clear.
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 1, 0, 8'(i), i, 8'd0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'd9, 8, 8'd0, 1, 1, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 1, 0, 8'd0, 7 - i, 8'(8 - i), 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'd0, 0, 8'd1, 1, 0, 0));
    // Switch to FIFO, short burst, then wrap with a full rd+wr in the middle.
    vecs.push_back(mk(0, 0, 0, 0, 8'd0, 0, 8'd1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd10, 1, 8'd1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd20, 2, 8'd1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd30, 3, 8'd1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 2, 8'd10, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 1, 8'd20, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 0, 8'd30, 0, 0, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 0, 0, 8'(i), i, 8'd30, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'd77, 8, 8'd1, 0, 0, 0));
    for (int i = 2; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 0, 8'd0, 9 - i, 8'(i), 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 0, 8'd77, 0, 0, 0));
    // Back to LIFO: rd+wr replaces top; mode request ignored until empty and idle.
    vecs.push_back(mk(0, 0, 1, 0, 8'd0, 0, 8'd77, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'd10, 1, 8'd77, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'd20, 2, 8'd77, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'd30, 3, 8'd77, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 8'd99, 3, 8'd30, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'd0, 2, 8'd99, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0, 2, 8'd99, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 1, 8'd20, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 0, 8'd10, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'd0, 0, 8'd10, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'd42, 1, 8'd10, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 0, 8'd42, 0, 0, 0));
    // Underflow, rd+wr on empty, clear, and set-wins-over-clear.
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 0, 8'd42, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 8'd5, 1, 8'd42, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 8'd0, 1, 8'd42, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'd0, 0, 8'd5, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'd0, 0, 8'd5, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 8'd0, 0, 8'd5, 0, 0, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 0, 0, 8'(i), i, 8'd5, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'd9, 8, 8'd5, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'd9, 8, 8'd5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'd0, 8, 8'd5, 0, 0, 0));
    for (int i = 1; i <= 8; i++) vecs.push_back(mk(0, 1, 0, 0, 8'd0, 8 - i, 8'(i), 0, 0, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].md, vecs[i].clr, vecs[i].d);
      chk_state($sformatf("vec%0d", i), vecs[i].e_used, vecs[i].e_q,
                vecs[i].e_mode, vecs[i].e_ovf, vecs[i].e_udf);
    end

    // Asynchronous reset mid-cycle with a non-trivial state.
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk_state("pre_rst", 5, 8'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    #2 arst_n = 1'b0;
    #1;
    chk_state("async_rst", 0, 8'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3 arst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'd7);
    chk_state("post_rst_wr", 1, 8'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    chk_state("post_rst_rd", 0, 8'd7, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
